// File: rtl/flood_fill.sv
// Region-grow reveal of zero tiles: snapshot maps on start, grow one neighbourhood per cycle, emit the mask once.
// Latency: 1 CHECK cycle + (iterations+1) EXPAND cycles + 1 APPLY cycle; start is ignored while busy, nothing queued.
// Optional FLOOD_DIAG_EN build switch selects 8-connected growth (default 4-connected).
module flood_fill #(
    parameter int GRID_SIZE   = 8,
    parameter int TOTAL_TILES = GRID_SIZE * GRID_SIZE,
    parameter int INDEX_BITS  = $clog2(TOTAL_TILES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [INDEX_BITS-1:0]  start_index,
    input  logic [TOTAL_TILES-1:0] zero_map,
    input  logic [TOTAL_TILES-1:0] mine_map,
    input  logic [TOTAL_TILES-1:0] flagged,
    output logic [TOTAL_TILES-1:0] flood_update,
    output logic                   flood_apply,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE, CHECK, EXPAND, APPLY} state_t;

    function automatic logic [TOTAL_TILES-1:0] col_mask(input int col);
        logic [TOTAL_TILES-1:0] m;
        m = '0;
        for (int i = 0; i < TOTAL_TILES; i++) begin
            m[i] = ((i % GRID_SIZE) == col);
        end
        return m;
    endfunction

    localparam logic [TOTAL_TILES-1:0] NOT_FIRST_COL = ~col_mask(0);
    localparam logic [TOTAL_TILES-1:0] NOT_LAST_COL  = ~col_mask(GRID_SIZE - 1);

    // Column masks stop horizontal moves wrapping across rows; vertical shifts fall off the ends.
    function automatic logic [TOTAL_TILES-1:0] nbr(input logic [TOTAL_TILES-1:0] src);
        logic [TOTAL_TILES-1:0] l_ok;
        logic [TOTAL_TILES-1:0] r_ok;
        logic [TOTAL_TILES-1:0] n;
        l_ok = src & NOT_FIRST_COL;
        r_ok = src & NOT_LAST_COL;
        n = (r_ok << 1) | (l_ok >> 1) | (src << GRID_SIZE) | (src >> GRID_SIZE);
`ifdef FLOOD_DIAG_EN
        n = n | (r_ok << (GRID_SIZE + 1)) | (l_ok << (GRID_SIZE - 1))
              | (r_ok >> (GRID_SIZE - 1)) | (l_ok >> (GRID_SIZE + 1));
`endif
        return n;
    endfunction

    state_t                 state_q, state_d;
    logic [TOTAL_TILES-1:0] region_q, region_d;
    logic [TOTAL_TILES-1:0] zero_q, zero_d;
    logic [TOTAL_TILES-1:0] mine_q, mine_d;
    logic [TOTAL_TILES-1:0] flag_q, flag_d;

    logic [TOTAL_TILES-1:0] seed_oh;
    logic [TOTAL_TILES-1:0] grow;
    logic                   seed_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            region_q <= '0;
            zero_q   <= '0;
            mine_q   <= '0;
            flag_q   <= '0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            zero_q   <= zero_d;
            mine_q   <= mine_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        region_d     = region_q;
        zero_d       = zero_q;
        mine_d       = mine_q;
        flag_d       = flag_q;
        flood_update = '0;
        flood_apply  = 1'b0;
        done         = 1'b0;
        busy         = (state_q != IDLE);
        seed_oh      = {{(TOTAL_TILES-1){1'b0}}, 1'b1} << start_index;
        grow         = nbr(region_q & zero_q) & ~mine_q & ~flag_q;
        // Region is still the one-hot seed in CHECK; an out-of-range index leaves it empty.
        seed_bad     = (region_q == '0) || (|(region_q & (mine_q | flag_q | ~zero_q)));

        case (state_q)
            IDLE: begin
                if (start) begin
                    zero_d   = zero_map;
                    mine_d   = mine_map;
                    flag_d   = flagged;
                    region_d = seed_oh;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (seed_bad) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                if ((region_q | grow) == region_q) begin
                    state_d = APPLY;
                end else begin
                    region_d = region_q | grow;
                end
            end
            APPLY: begin
                flood_update = region_q;
                flood_apply  = 1'b1;
                done         = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/flood_fill.md
FLOOD_FILL -- requirements
Module: flood_fill

Interface
REQ-001 SHALL have parameter GRID_SIZE, default 8, tiles per row/column.
REQ-002 SHALL have parameter TOTAL_TILES, default GRID_SIZE*GRID_SIZE, tile count.
REQ-003 SHALL have parameter INDEX_BITS, default $clog2(TOTAL_TILES), tile index width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  single-cycle request to flood from start_index.
REQ-007 SHALL have port start_index  input  INDEX_BITS  seed tile; index = row*GRID_SIZE+col.
REQ-008 SHALL have port zero_map  input  TOTAL_TILES  1 = non-mine tile with zero adjacent mines.
REQ-009 SHALL have port mine_map  input  TOTAL_TILES  1 = mine.
REQ-010 SHALL have port flagged  input  TOTAL_TILES  current flag state.
REQ-011 SHALL have port flood_update  output  TOTAL_TILES  reveal mask; valid only while flood_apply=1.
REQ-012 SHALL have port flood_apply  output  1  one-cycle pulse, flood_update valid.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of every accepted request.

Function
REQ-015 SHALL implement states IDLE, CHECK, EXPAND, APPLY.
REQ-016 In IDLE, start=1 SHALL be accepted: snapshot zero_map, mine_map, flagged; load region R = one-hot(start_index); go CHECK.
REQ-017 start while busy=1 SHALL be ignored, no queuing.
REQ-018 CHECK: seed tile mine, flagged, or zero_map bit 0 -> pulse done, flood_apply stays 0, return IDLE; else go EXPAND.
REQ-019 EXPAND, one iteration per cycle: grow = nbr(R & zero_snap) & ~mine_snap & ~flag_snap; R <= R | grow.
REQ-020 EXPAND SHALL go APPLY in the cycle after the first iteration where R | grow == R.
REQ-021 APPLY SHALL drive flood_update=R, flood_apply=1, done=1 for exactly one cycle, then IDLE.
REQ-022 flood_update SHALL be all zeros whenever flood_apply=0.
REQ-023 nbr() SHALL never wrap: col 0 has no left neighbour, col GRID_SIZE-1 no right, row 0 no up, last row no down.
REQ-024 R SHALL be monotone; EXPAND SHALL terminate in at most TOTAL_TILES iterations.
REQ-025 Already-revealed tiles MAY appear in flood_update; the consumer ORs masks, so this is harmless.
REQ-026 Input changes after acceptance SHALL not affect the running request.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, R=0, snapshots=0, flood_update=0, flood_apply=0, busy=0, done=0.
REQ-028 Reset mid-request SHALL abort with no flood_apply or done pulse after release.

Configuration
REQ-029 Macro FLOOD_DIAG_EN SHALL select connectivity.
REQ-030 With FLOOD_DIAG_EN defined, nbr() SHALL be 8-connected (orthogonal plus diagonal).
REQ-031 Without FLOOD_DIAG_EN, nbr() SHALL be 4-connected (orthogonal only); all other behaviour unchanged.

Verification
REQ-032 zero_map all ones, mines/flags 0, start_index 0 -> one flood_apply pulse, flood_update=64'hFFFF_FFFF_FFFF_FFFF.
REQ-033 mine_map bit 27, start_index 27 -> done pulse in CHECK cycle, flood_apply never asserted.
REQ-034 zero_map only bit 7, no mines, start 7 -> mask 64'hC0C0 with FLOOD_DIAG_EN, 64'h80C0 without; bit 8 never set.
REQ-035 zero_map all ones, flagged=64'h0000_0000_FF00_0000, start 0 -> flood_update=64'h0000_0000_00FF_FFFF.
REQ-036 zero_map only bit 36, start 36 sampled at edge E0 -> CHECK after E0, EXPAND after E1 and E2, flood_apply high between E3 and E4.
REQ-037 start re-asserted during EXPAND ignored; rst=0 mid-EXPAND -> outputs 0 immediately, no later pulse.
